adc_burst_packer: RTL
=====================

ADC_BURST_PACKER -- requirements
Module: adc_burst_packer

Interface
REQ-001 The block SHALL have parameter FIFO_DEPTH, default 16, the number of 64-bit FIFO entries (power of two, minimum 4).
REQ-002 The block SHALL have port aclk, input, 1, the single clock.
REQ-003 The block SHALL have port areset, input, 1, the reset: synchronous and active-high.
REQ-004 The block SHALL have port s_axis_tvalid, input, 1, input word valid; there is no s_axis_tready and the source cannot be stalled.
REQ-005 The block SHALL have port s_axis_tlast, input, 1, last word of the packet.
REQ-006 The block SHALL have port s_axis_tdata, input, 32, sample word as produced by the ADC stage ({marker[1:0], a[14:0], b[14:0]}).
REQ-007 The block SHALL have port m_axis_tvalid, output, 1, output entry valid.
REQ-008 The block SHALL have port m_axis_tready, input, 1, downstream accept.
REQ-009 The block SHALL have port m_axis_tlast, output, 1, last entry of the packet.
REQ-010 The block SHALL have port m_axis_tdata, output, 64, packed entry.
REQ-011 The block SHALL have port fifo_level, output, clog2(FIFO_DEPTH)+1, number of occupied entries.
REQ-012 The block SHALL have port overflow, output, 1, sticky flag for a truncation or drop event.
REQ-013 The block SHALL have port clear_overflow, input, 1, clears overflow.
REQ-014 The block SHALL have port drop_count, output, 32, number of dropped input words.
REQ-015 The block SHALL have port packet_count, output, 32, number of packets fully delivered downstream.

Function
REQ-016 The block SHALL run a state machine with three states: IDLE (no half-word held), HALF (low half held), DISCARD (dropping the rest of a packet).
REQ-017 In IDLE, a valid word SHALL be latched as the low half [31:0] and the state SHALL move to HALF, unless tlast=1, in which case the entry completes immediately.
REQ-018 In HALF, a valid word SHALL fill the high half [63:32] and complete the entry; the state SHALL return to IDLE.
REQ-019 An entry completed by a tlast word in the low half SHALL have its high half padded with 32'h0000_0000 (marker 00 flags padding).
REQ-020 A completed entry SHALL carry tlast equal to the s_axis_tlast of its completing word, except as modified by REQ-024.
REQ-021 A completed entry SHALL be pushed at the same clock edge at which its completing word is sampled.
REQ-022 The FIFO output SHALL be first-word-fall-through, with m_axis_tvalid = (fifo_level != 0); a push into an empty FIFO SHALL be visible on the cycle after the push edge.
REQ-023 A pop SHALL occur when m_axis_tvalid && m_axis_tready; tdata and tlast SHALL stay stable while tvalid=1 and tready=0.
REQ-024 Truncation: if a push fills the last free slot with no pop in that cycle and the completing word has tlast=0, then:
- the entry SHALL be pushed with tlast forced to 1;
- overflow SHALL be set;
- the state SHALL go to DISCARD.
REQ-025 Drop: if an entry completes while the FIFO is full and no pop occurs that cycle, then:
- the entry SHALL be discarded and drop_count incremented by its word count (1 or 2);
- overflow SHALL be set;
- the state SHALL go to DISCARD if tlast=0, otherwise to IDLE.
REQ-026 If an entry completes while the FIFO is full and a pop occurs in the same cycle, the push SHALL be accepted and fifo_level SHALL be unchanged.
REQ-027 In DISCARD, each valid word SHALL be dropped with drop_count +1; a word with tlast=1 SHALL be dropped and the state SHALL return to IDLE.
REQ-028 fifo_level SHALL increase by 1 on push only, decrease by 1 on pop only, and be unchanged on simultaneous push and pop; pointers SHALL wrap modulo FIFO_DEPTH.
REQ-029 packet_count SHALL increment on each pop with m_axis_tlast=1.
REQ-030 drop_count and packet_count SHALL saturate at 32'hFFFF_FFFF.
REQ-031 If clear_overflow and a new overflow event occur in the same cycle, overflow SHALL be 1 (set wins).

Reset
REQ-032 When areset=1 at a clock edge, the block SHALL enter IDLE, clear the FIFO pointers, discard any held half-word and pending entries, and set m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata=0, fifo_level=0, overflow=0, drop_count=0, packet_count=0.
REQ-033 Input words presented during reset SHALL be ignored and SHALL NOT be counted.

Configuration
REQ-034 With macro ADC_BURST_PACKER_STATS_EN defined, drop_count and packet_count SHALL behave as in REQ-025, REQ-027, REQ-029 and REQ-030.
REQ-035 Without ADC_BURST_PACKER_STATS_EN, drop_count and packet_count SHALL be constant 0, no counter logic SHALL be synthesized, and all other behaviour SHALL be identical.

Verification
REQ-036 Verification SHALL cover: 4 words A,B,C,D (tlast on D), m_axis_tready=1 -> two entries {B,A} and {D,C}, tlast on the second only, packet_count=1.
REQ-037 Verification SHALL cover: 3 words A,B,C (tlast on C) -> entries {B,A} and {0,C} with tlast=1.
REQ-038 Verification SHALL cover: FIFO_DEPTH=4, m_axis_tready=0, 10-word packet -> 4 entries, the 4th with tlast forced to 1, overflow=1, drop_count=2, then IDLE.
REQ-039 Verification SHALL cover: FIFO full, then a 2-word packet with a pop in the completing cycle -> entry accepted, fifo_level stays 4, overflow=0.
REQ-040 Verification SHALL cover: areset asserted with the FIFO at level 3 and state HALF -> next cycle fifo_level=0, m_axis_tvalid=0, and a following single-word packet yields {0,W}.
REQ-041 Verification SHALL cover: build without ADC_BURST_PACKER_STATS_EN and repeat the REQ-038 scenario -> identical stream and overflow behaviour, drop_count=0 throughout.

Source files
------------

// File: rtl/adc_burst_packer.sv
// ADC burst packer: pairs 32-bit sample words into 64-bit FWFT FIFO entries.
// Optional drop/packet statistics under `ADC_BURST_PACKER_STATS_EN.
module adc_burst_packer #(
   parameter int FIFO_DEPTH = 16
) (
   input  logic                          aclk,
   input  logic                          areset,
   input  logic                          s_axis_tvalid,
   input  logic                          s_axis_tlast,
   input  logic [31:0]                   s_axis_tdata,
   output logic                          m_axis_tvalid,
   input  logic                          m_axis_tready,
   output logic                          m_axis_tlast,
   output logic [63:0]                   m_axis_tdata,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
   output logic                          overflow,
   input  logic                          clear_overflow,
   output logic [31:0]                   drop_count,
   output logic [31:0]                   packet_count
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam logic [AW:0] LVL_FULL = (AW+1)'(FIFO_DEPTH);
   localparam logic [AW:0] LVL_LAST = (AW+1)'(FIFO_DEPTH - 1);

   typedef enum logic [1:0] {
      IDLE,
      HALF,
      DISCARD
   } state_t;

   state_t        state;
   logic [31:0]   low_q;
   logic [64:0]   mem [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [AW:0]   level;

   logic        complete;
   logic [63:0] entry;
   logic        pop;
   logic        full;
   logic        drop;
   logic        push;
   logic        trunc;
   logic        push_last;
   logic [64:0] head;

   always_comb begin
      complete = 1'b0;
      entry    = {32'h0000_0000, s_axis_tdata};
      unique case (state)
         IDLE: complete = s_axis_tvalid && s_axis_tlast;
         HALF: begin
            complete = s_axis_tvalid;
            entry    = {s_axis_tdata, low_q};
         end
         default: ;
      endcase
   end

   assign pop       = m_axis_tvalid && m_axis_tready;
   assign full      = (level == LVL_FULL);
   assign drop      = complete && full && !pop;
   assign push      = complete && !drop;
   // Taking the last free slot mid-packet ends the packet early.
   assign trunc     = push && !pop && (level == LVL_LAST) && !s_axis_tlast;
   assign push_last = s_axis_tlast || trunc;

   always_ff @(posedge aclk) begin
      if (areset) begin
         state <= IDLE;
         low_q <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (s_axis_tvalid && !s_axis_tlast) begin
                  low_q <= s_axis_tdata;
                  state <= HALF;
               end
            end
            HALF: begin
               if (s_axis_tvalid)
                  state <= ((drop || trunc) && !s_axis_tlast) ? DISCARD : IDLE;
            end
            DISCARD: begin
               if (s_axis_tvalid && s_axis_tlast)
                  state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   always_ff @(posedge aclk) begin
      if (areset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (push)
            wr_ptr <= wr_ptr + 1'b1;
         if (pop)
            rd_ptr <= rd_ptr + 1'b1;
         if (push && !pop)
            level <= level + 1'b1;
         else if (pop && !push)
            level <= level - 1'b1;
      end
   end

   always_ff @(posedge aclk) begin
      if (push && !areset)
         mem[wr_ptr] <= {push_last, entry};
   end

   always_ff @(posedge aclk) begin
      if (areset)
         overflow <= 1'b0;
      else if (drop || trunc)
         overflow <= 1'b1;
      else if (clear_overflow)
         overflow <= 1'b0;
   end

   assign head          = mem[rd_ptr];
   assign m_axis_tvalid = (level != '0);
   assign m_axis_tdata  = m_axis_tvalid ? head[63:0] : 64'h0;
   assign m_axis_tlast  = m_axis_tvalid && head[64];
   assign fifo_level    = level;

`ifdef ADC_BURST_PACKER_STATS_EN
   logic [1:0]  drop_inc;
   logic [32:0] drop_sum;
   logic [32:0] pkt_sum;

   always_comb begin
      drop_inc = 2'd0;
      if (state == DISCARD && s_axis_tvalid)
         drop_inc = 2'd1;
      else if (drop)
         drop_inc = (state == HALF) ? 2'd2 : 2'd1;
   end

   assign drop_sum = {1'b0, drop_count} + {31'd0, drop_inc};
   assign pkt_sum  = {1'b0, packet_count} + 33'd1;

   always_ff @(posedge aclk) begin
      if (areset) begin
         drop_count   <= '0;
         packet_count <= '0;
      end else begin
         if (drop_inc != 2'd0)
            drop_count <= drop_sum[32] ? 32'hFFFF_FFFF : drop_sum[31:0];
         if (pop && m_axis_tlast)
            packet_count <= pkt_sum[32] ? 32'hFFFF_FFFF : pkt_sum[31:0];
      end
   end
`else
   assign drop_count   = 32'h0;
   assign packet_count = 32'h0;
`endif

endmodule
